// File: rtl/pipe_stall_controller_if.sv
// Bundle between the ID-stage decode/forwarding logic and the stall controller.
// slave: controller side (decode fields in, pipeline controls out); master: driver side.
interface pipe_stall_controller_if;
   logic [3:0]  opcode_id;
   logic [3:0]  id_op1;
   logic [3:0]  id_op2;
   logic        id_uses_op2;
   logic        id_is_halt;
   logic [3:0]  opcode_ex;
   logic [3:0]  ex_op1;
   logic [1:0]  hazard_detected;
   logic        branch_taken;
   logic        pc_we;
   logic        ifid_we;
   logic        ifid_flush;
   logic        idex_bubble;
   logic        halted;
   logic [15:0] stall_count;
   logic [15:0] flush_count;

   modport master (
      output opcode_id, id_op1, id_op2, id_uses_op2, id_is_halt,
      output opcode_ex, ex_op1, hazard_detected, branch_taken,
      input  pc_we, ifid_we, ifid_flush, idex_bubble, halted,
      input  stall_count, flush_count
   );

   modport slave (
      input  opcode_id, id_op1, id_op2, id_uses_op2, id_is_halt,
      input  opcode_ex, ex_op1, hazard_detected, branch_taken,
      output pc_we, ifid_we, ifid_flush, idex_bubble, halted,
      output stall_count, flush_count
   );
endinterface

// File: rtl/pipe_stall_controller.sv
// Pipeline interlock/flush controller: load-use and branch-compare stalls, taken-branch
// flush, HALT freeze. Ports: clk, rst_n (async, active low), bus (slave modport).
// Optional perf counters enabled by defining PIPE_PERF_CNT_EN; otherwise tied to zero.
module pipe_stall_controller (
   input  logic                    clk,
   input  logic                    rst_n,
   pipe_stall_controller_if.slave  bus
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      BSTALL = 2'd1,
      HALT   = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic ex_is_load;
   logic id_is_branch;
   logic load_use;
   logic br_dep;
   logic stall;
   logic flush;

   assign ex_is_load = (bus.opcode_ex == 4'b0100) ||
                       (bus.opcode_ex == 4'b0110);
   assign id_is_branch = (bus.opcode_id[3:2] == 2'b10);
   assign load_use = ex_is_load &&
                     ((bus.ex_op1 == bus.id_op1) ||
                      (bus.id_uses_op2 && (bus.ex_op1 == bus.id_op2)));
   assign br_dep = id_is_branch && bus.hazard_detected[1] &&
                   (bus.ex_op1 == bus.id_op1) &&
                   (bus.opcode_ex != 4'b0000);

   // EX-operand hazards are resolved by forwarding; never a stall source
   logic unused_haz0;
   assign unused_haz0 = bus.hazard_detected[0];

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   // next state
   always_comb begin
      state_nxt = state;
      unique case (state)
         RUN: begin
            if (br_dep && ex_is_load)      state_nxt = BSTALL;
            else if (br_dep || load_use)   state_nxt = RUN;
            else if (bus.id_is_halt)       state_nxt = HALT;
            else                           state_nxt = RUN;
         end
         BSTALL:  state_nxt = RUN;
         HALT:    state_nxt = HALT;
         default: state_nxt = RUN;
      endcase
   end

   // outputs; stall has priority so a branch is never flushed while stalled
   always_comb begin
      stall = 1'b0;
      flush = 1'b0;
      unique case (state)
         RUN: begin
            if (br_dep || load_use || bus.id_is_halt) stall = 1'b1;
            else if (bus.branch_taken)                flush = 1'b1;
         end
         BSTALL:  stall = 1'b1;
         HALT:    stall = 1'b1;
         default: stall = 1'b1;
      endcase
   end

   // reset forces the stall pattern without waiting for an edge
   assign bus.pc_we       = rst_n & ~stall;
   assign bus.ifid_we     = rst_n & ~stall;
   assign bus.ifid_flush  = rst_n & flush;
   assign bus.idex_bubble = ~rst_n | stall;
   assign bus.halted      = rst_n & (state == HALT);

`ifdef PIPE_PERF_CNT_EN
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;
   logic        stall_inc;

   assign stall_inc = ~bus.pc_we && (state != HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= 16'h0000;
         flush_cnt <= 16'h0000;
      end else begin
         if (stall_inc && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
         if (bus.ifid_flush && (flush_cnt != 16'hFFFF))
            flush_cnt <= flush_cnt + 16'd1;
      end
   end

   assign bus.stall_count = stall_cnt;
   assign bus.flush_count = flush_cnt;
`else
   assign bus.stall_count = 16'h0000;
   assign bus.flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stall_controller.sv
// Directed bench for pipe_stall_controller: expected control vectors are queued
// at stimulus time and popped when the combinational outputs are sampled.
module tb_pipe_stall_controller;

   logic clk;
   logic rst_n;
   int   n_asrt;
   int   n_fail;

   pipe_stall_controller_if bus ();

   pipe_stall_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pc_we, ifid_we, ifid_flush, idex_bubble, halted}
   localparam logic [4:0] O_RUN   = 5'b11000;
   localparam logic [4:0] O_STALL = 5'b00010;
   localparam logic [4:0] O_FLUSH = 5'b11100;
   localparam logic [4:0] O_HALT  = 5'b00011;
   localparam logic [4:0] O_RST   = 5'b00010;

   logic [4:0] exp_q[$];

   function automatic logic [4:0] obs_ctl();
      return {bus.pc_we, bus.ifid_we, bus.ifid_flush,
              bus.idex_bubble, bus.halted};
   endfunction

   function automatic logic [15:0] cnt(input int n);
`ifdef PIPE_PERF_CNT_EN
      return n[15:0];
`else
      return 16'h0000 & n[15:0];
`endif
   endfunction

   task automatic check_ctl(input string tag);
      logic [4:0] e;
      logic [4:0] o;
      if (exp_q.size() == 0) begin
         n_asrt++;
         n_fail++;
         $display("FAIL %s scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         o = obs_ctl();
         n_asrt++;
         assert (o === e) else begin
            n_fail++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, o, e);
         end
      end
   endtask

   task automatic check_cnt(input string tag, input logic [15:0] es,
                            input logic [15:0] ef);
      n_asrt++;
      assert (bus.stall_count === es) else begin
         n_fail++;
         $error("FAIL %s stall_count observed=%h expected=%h",
                tag, bus.stall_count, es);
      end
      n_asrt++;
      assert (bus.flush_count === ef) else begin
         n_fail++;
         $error("FAIL %s flush_count observed=%h expected=%h",
                tag, bus.flush_count, ef);
      end
   endtask

   task automatic drive(input logic [3:0] op_id, input logic [3:0] r1,
                        input logic [3:0] r2, input logic u2,
                        input logic hlt, input logic [3:0] op_ex,
                        input logic [3:0] rd, input logic [1:0] hz,
                        input logic bt);
      bus.opcode_id       = op_id;
      bus.id_op1          = r1;
      bus.id_op2          = r2;
      bus.id_uses_op2     = u2;
      bus.id_is_halt      = hlt;
      bus.opcode_ex       = op_ex;
      bus.ex_op1          = rd;
      bus.hazard_detected = hz;
      bus.branch_taken    = bt;
   endtask

   // called at posedge+1: apply inputs, queue expectation, sample mid-cycle,
   // then advance past the next rising edge
   task automatic step(input string tag, input logic [4:0] e);
      exp_q.push_back(e);
      #3;
      check_ctl(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(4'b0001, 4'd1, 4'd2, 1'b1, 1'b0, 4'b0000, 4'd0, 2'b00, 1'b0);
   endtask

   initial begin
      n_asrt = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      idle();
      #2;
      exp_q.push_back(O_RST);
      check_ctl("reset_out");
      check_cnt("reset_cnt", 16'h0000, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      idle();
      step("idle_run", O_RUN);

      // LW r3 in EX, ADD reading r3 in ID
      drive(4'b0001, 4'd3, 4'd2, 1'b1, 1'b0, 4'b0110, 4'd3, 2'b00, 1'b0);
      step("load_use_op1", O_STALL);
      drive(4'b0001, 4'd3, 4'd2, 1'b1, 1'b0, 4'b0000, 4'd3, 2'b00, 1'b0);
      step("load_use_release", O_RUN);
      check_cnt("load_use_cnt", cnt(1), cnt(0));

      // second source only matters when it is actually read
      drive(4'b0010, 4'd1, 4'd7, 1'b1, 1'b0, 4'b0100, 4'd7, 2'b00, 1'b0);
      step("load_use_op2", O_STALL);
      drive(4'b0010, 4'd1, 4'd7, 1'b0, 1'b0, 4'b0100, 4'd7, 2'b00, 1'b0);
      step("op2_unused", O_RUN);

      // load r5 feeding ID branch: RUN detect + BSTALL
      drive(4'b1000, 4'd5, 4'd0, 1'b0, 1'b0, 4'b0100, 4'd5, 2'b10, 1'b0);
      step("ld_br_detect", O_STALL);
      drive(4'b1000, 4'd5, 4'd0, 1'b0, 1'b0, 4'b0000, 4'd0, 2'b00, 1'b1);
      step("ld_br_bstall", O_STALL);
      drive(4'b1000, 4'd5, 4'd0, 1'b0, 1'b0, 4'b0000, 4'd0, 2'b00, 1'b0);
      step("ld_br_release", O_RUN);
      check_cnt("ld_br_cnt", cnt(4), cnt(0));

      // ALU r5 feeding ID branch: single stall, no BSTALL
      drive(4'b1000, 4'd5, 4'd0, 1'b0, 1'b0, 4'b0001, 4'd5, 2'b10, 1'b0);
      step("alu_br_detect", O_STALL);
      drive(4'b1000, 4'd5, 4'd0, 1'b0, 1'b0, 4'b0000, 4'd0, 2'b00, 1'b0);
      step("alu_br_release", O_RUN);
      check_cnt("alu_br_cnt", cnt(5), cnt(0));

      // EX operand hazard alone never stalls
      drive(4'b0001, 4'd5, 4'd5, 1'b1, 1'b0, 4'b0001, 4'd5, 2'b01, 1'b0);
      step("haz0_no_stall", O_RUN);
      // branch hazard against a bubble in EX is not a dependency
      drive(4'b1001, 4'd0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'd0, 2'b10, 1'b0);
      step("br_vs_bubble", O_RUN);

      // taken branch flush
      drive(4'b1000, 4'd2, 4'd0, 1'b0, 1'b0, 4'b0001, 4'd9, 2'b00, 1'b1);
      step("flush", O_FLUSH);
      idle();
      step("after_flush", O_RUN);
      check_cnt("flush_cnt", cnt(5), cnt(1));

      // dependency wins over taken branch
      drive(4'b1000, 4'd5, 4'd0, 1'b0, 1'b0, 4'b0001, 4'd5, 2'b10, 1'b1);
      step("dep_beats_flush", O_STALL);
      check_cnt("dep_flush_cnt", cnt(6), cnt(1));

      // load-use with HALT: stall first, then HALT taken
      drive(4'b0001, 4'd3, 4'd0, 1'b0, 1'b1, 4'b0110, 4'd3, 2'b00, 1'b0);
      step("halt_lu_stall", O_STALL);
      drive(4'b0001, 4'd3, 4'd0, 1'b0, 1'b1, 4'b0000, 4'd0, 2'b00, 1'b1);
      step("halt_enter", O_STALL);
      for (int i = 0; i < 20; i++) begin
         drive($urandom_range(15, 0), $urandom_range(15, 0),
               $urandom_range(15, 0), $urandom_range(1, 0),
               $urandom_range(1, 0), $urandom_range(15, 0),
               $urandom_range(15, 0), $urandom_range(3, 0),
               $urandom_range(1, 0));
         step("halt_hold", O_HALT);
      end
      check_cnt("halt_cnt", cnt(8), cnt(1));

      // async reset inside HALT, away from any edge
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.push_back(O_RST);
      check_ctl("async_rst_halt");
      check_cnt("async_rst_cnt", 16'h0000, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle();
      step("post_rst_run", O_RUN);

      // reset aborts BSTALL
      drive(4'b1011, 4'd6, 4'd0, 1'b0, 1'b0, 4'b0110, 4'd6, 2'b10, 1'b0);
      step("bstall_enter", O_STALL);
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.push_back(O_RST);
      check_ctl("async_rst_bstall");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step("bstall_aborted", O_RUN);

      // long load-use run: saturates with counters, stays zero without
      drive(4'b0001, 4'd4, 4'd0, 1'b0, 1'b0, 4'b0100, 4'd4, 2'b00, 1'b0);
      for (int i = 0; i < 65540; i++) begin
         @(posedge clk);
      end
      #1;
`ifdef PIPE_PERF_CNT_EN
      check_cnt("stall_saturate", 16'hFFFF, 16'h0000);
`else
      check_cnt("stall_saturate", 16'h0000, 16'h0000);
`endif
      step("sat_still_stall", O_STALL);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end

endmodule
